cordic_atan_lut: RTL and testbench



---
 rtl/cordic_atan_lut.sv | 62 ++++++
 tb/tb_cordic_atan_lut.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_atan_lut.sv
// CORDIC micro-rotation angle ROM: entry i = atan(2^-i) in Q3.13, one registered read port.
// Optional LUT_READ_ENABLE_EN adds an rd_en port that gates the output register.
module cordic_atan_lut #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [ADDR_WIDTH-1:0] raddr,
`ifdef LUT_READ_ENABLE_EN
  input  logic                  rd_en,
`endif
  output logic [DATA_WIDTH-1:0] data_out
);

  generate
    if (DATA_WIDTH != 16) begin : g_bad_dw
      $error("cordic_atan_lut: only DATA_WIDTH=16 (Q3.13) is supported");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 6) begin : g_bad_aw
      $error("cordic_atan_lut: ADDR_WIDTH must be in 1..6");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] rom_word;

  // round(atan(2^-i) * 8192); entries past 13 round to zero
  always_comb begin
    rom_word = '0;
    case (int'(raddr))
      0:  rom_word = 16'd6434;
      1:  rom_word = 16'd3798;
      2:  rom_word = 16'd2007;
      3:  rom_word = 16'd1019;
      4:  rom_word = 16'd511;
      5:  rom_word = 16'd256;
      6:  rom_word = 16'd128;
      7:  rom_word = 16'd64;
      8:  rom_word = 16'd32;
      9:  rom_word = 16'd16;
      10: rom_word = 16'd8;
      11: rom_word = 16'd4;
      12: rom_word = 16'd2;
      13: rom_word = 16'd1;
      default: rom_word = '0;
    endcase
  end

  // reset is synchronous despite the historical port name
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      data_out <= '0;
`ifdef LUT_READ_ENABLE_EN
    end else if (rd_en) begin
`else
    end else begin
`endif
      data_out <= rom_word;
    end
  end

endmodule

// File: tb/tb_cordic_atan_lut.sv
// Directed bench for cordic_atan_lut: reset, sweep, wrap, reset-pulse immunity, mid-stream reset.
`timescale 1ns/1ps
module tb_cordic_atan_lut;

  logic        clk;
  logic        arst_n;
  logic [3:0]  raddr;
  logic [15:0] data_out;
`ifdef LUT_READ_ENABLE_EN
  logic        rd_en;
`endif

  int checks;
  int failures;

  logic [15:0] exp_tab [0:15];

  cordic_atan_lut #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .raddr    (raddr),
`ifdef LUT_READ_ENABLE_EN
    .rd_en    (rd_en),
`endif
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    arst_n = 1'b0;
    raddr  = 4'd5;
    repeat (2) @(negedge clk);
    checks++;
    if (data_out !== 16'd0) begin
      failures++;
      $display("FAIL reset_hold actual=%0d required=%0d", data_out, 0);
    end
    arst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (data_out !== 16'd256) begin
      failures++;
      $display("FAIL reset_release actual=%0d required=%0d", data_out, 256);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] prev;
    prev = 16'd256;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (data_out !== prev) begin
        failures++;
        $display("FAIL sweep_addr%0d actual=%0d required=%0d", i - 1, data_out, prev);
      end
      raddr = 4'(i);
      #1;
      checks++;
      if (data_out !== prev) begin
        failures++;
        $display("FAIL sweep_latency%0d actual=%0d required=%0d", i, data_out, prev);
      end
      prev = exp_tab[i];
    end
    @(negedge clk);
    checks++;
    if (data_out !== prev) begin
      failures++;
      $display("FAIL sweep_addr15 actual=%0d required=%0d", data_out, prev);
    end
  endtask

  task automatic test_wrap();
    raddr = raddr + 4'd1;
    #1;
    checks++;
    if (data_out !== 16'd0) begin
      failures++;
      $display("FAIL wrap_before actual=%0d required=%0d", data_out, 0);
    end
    @(negedge clk);
    checks++;
    if (data_out !== 16'd6434) begin
      failures++;
      $display("FAIL wrap_after actual=%0d required=%0d", data_out, 6434);
    end
  endtask

  task automatic test_reset_pulse();
    #1;
    arst_n = 1'b0;
    #2;
    arst_n = 1'b1;
    checks++;
    if (data_out !== 16'd6434) begin
      failures++;
      $display("FAIL pulse_immediate actual=%0d required=%0d", data_out, 6434);
    end
    @(negedge clk);
    checks++;
    if (data_out !== 16'd6434) begin
      failures++;
      $display("FAIL pulse_next_edge actual=%0d required=%0d", data_out, 6434);
    end
  endtask

  task automatic test_midstream_reset();
    raddr = 4'd1;
    @(negedge clk);
    raddr = 4'd2;
    @(negedge clk);
    raddr  = 4'd3;
    arst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (data_out !== 16'd0) begin
      failures++;
      $display("FAIL midreset_clear actual=%0d required=%0d", data_out, 0);
    end
    arst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (data_out !== 16'd1019) begin
      failures++;
      $display("FAIL midreset_reload actual=%0d required=%0d", data_out, 1019);
    end
    raddr = 4'd4;
    @(negedge clk);
    checks++;
    if (data_out !== 16'd511) begin
      failures++;
      $display("FAIL midreset_stream actual=%0d required=%0d", data_out, 511);
    end
  endtask

`ifdef LUT_READ_ENABLE_EN
  task automatic test_rd_en();
    raddr = 4'd1;
    rd_en = 1'b1;
    @(negedge clk);
    checks++;
    if (data_out !== 16'd3798) begin
      failures++;
      $display("FAIL rden_load actual=%0d required=%0d", data_out, 3798);
    end
    raddr = 4'd2;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (data_out !== 16'd3798) begin
      failures++;
      $display("FAIL rden_hold actual=%0d required=%0d", data_out, 3798);
    end
    rd_en = 1'b1;
    @(negedge clk);
    checks++;
    if (data_out !== 16'd2007) begin
      failures++;
      $display("FAIL rden_resume actual=%0d required=%0d", data_out, 2007);
    end
    rd_en  = 1'b0;
    arst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (data_out !== 16'd0) begin
      failures++;
      $display("FAIL rden_reset actual=%0d required=%0d", data_out, 0);
    end
    arst_n = 1'b1;
    rd_en  = 1'b1;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    exp_tab = '{16'd6434, 16'd3798, 16'd2007, 16'd1019, 16'd511, 16'd256, 16'd128, 16'd64,
                16'd32, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1, 16'd0, 16'd0};
    arst_n = 1'b0;
    raddr  = 4'd0;
`ifdef LUT_READ_ENABLE_EN
    rd_en  = 1'b1;
`endif
    test_reset();
    test_sweep();
    test_wrap();
    test_reset_pulse();
    test_midstream_reset();
`ifdef LUT_READ_ENABLE_EN
    test_rd_en();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
